// File: rtl/ship_sprite_rom.sv
// ship_sprite_rom
// Pipelined sprite-line generator for the battleship board renderer. Each
// accepted request returns one WIDTH-bit pixel line for one of four cell
// sprites (SHIP, HIT, MISS, WATER), optionally mirrored vertically, with a
// frame-driven blink on HIT and an out-of-range row flag.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req_valid    request strobe
//   req_ready    block can accept a request this cycle (registered)
//   req_kind     sprite: 0 SHIP, 1 HIT, 2 MISS, 3 WATER
//   req_row      requested line index
//   req_mirror   vertical flip
//   frame_tick   one-cycle pulse per video frame
//   line_valid   line_pixels/line_row/row_err valid this cycle
//   line_pixels  pixel line, bit WIDTH-1 is the leftmost pixel
//   line_row     echo of req_row for the returned line
//   row_err      req_row >= HEIGHT for this line
//
// Pipeline: accept edge -> stage 1 (decode) -> stage 2 (pattern) -> outputs.
// A request accepted at edge N is presented on the outputs after edge N+2.

module ship_sprite_rom #(
  parameter int WIDTH        = 48,
  parameter int HEIGHT       = 48,
  parameter int ADDR_W       = 7,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [ADDR_W-1:0] req_row,
  input  logic              req_mirror,
  input  logic              frame_tick,
  output logic              line_valid,
  output logic [WIDTH-1:0]  line_pixels,
  output logic [ADDR_W-1:0] line_row,
  output logic              row_err
);

  typedef enum logic [1:0] {
    KIND_SHIP  = 2'd0,
    KIND_HIT   = 2'd1,
    KIND_MISS  = 2'd2,
    KIND_WATER = 2'd3
  } kind_e;

  localparam int                CNT_W    = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  // One extra bit so HEIGHT == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   HEIGHT_C = (ADDR_W + 1)'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'(HEIGHT - 1);
  localparam int                MISS_R_LO = HEIGHT / 2 - 4;
  localparam int                MISS_R_HI = HEIGHT / 2 + 3;
  localparam int                MISS_C_LO = WIDTH / 2 - 4;
  localparam int                MISS_C_HI = WIDTH / 2 + 3;

  logic              req_ready_q;
  logic              accept_s;

  logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  logic              s1_valid_q;
  logic [1:0]        s1_kind_q, s1_kind_d;
  logic              s1_err_q, s1_err_d;
  logic [ADDR_W-1:0] s1_r_q, s1_r_d;
  logic [ADDR_W-1:0] s1_row_q, s1_row_d;
  logic              s1_phase_q, s1_phase_d;

  logic              s2_valid_q;
  logic [WIDTH-1:0]  s2_pix_q, s2_pix_d;
  logic [ADDR_W-1:0] s2_row_q, s2_row_d;
  logic              s2_err_q, s2_err_d;

  logic              line_valid_q;
  logic [WIDTH-1:0]  line_pixels_q, line_pixels_d;
  logic [ADDR_W-1:0] line_row_q, line_row_d;
  logic              row_err_q, row_err_d;

  int                r_int;

  assign accept_s = req_valid && req_ready_q;

  // Blink counter next state: wraps at BLINK_FRAMES-1 and toggles the phase.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + CNT_W'(1);
      end
    end else begin
      blink_cnt_d   = blink_cnt_q;
    end
  end

  // Stage 1 next state: decode the request; out-of-range rows skip mirroring.
  always_comb begin
    s1_kind_d  = s1_kind_q;
    s1_err_d   = s1_err_q;
    s1_r_d     = s1_r_q;
    s1_row_d   = s1_row_q;
    s1_phase_d = s1_phase_q;
    if (accept_s) begin
      s1_kind_d  = req_kind;
      s1_err_d   = ({1'b0, req_row} >= HEIGHT_C);
      s1_row_d   = req_row;
      s1_phase_d = blink_phase_q;  // old phase even if frame_tick fires now
      if (req_mirror && !({1'b0, req_row} >= HEIGHT_C)) begin
        s1_r_d = ROW_MAX - req_row;
      end else begin
        s1_r_d = req_row;
      end
    end else begin
      s1_kind_d = s1_kind_q;
    end
  end

  // Stage 2 pattern generation: column c drives bit WIDTH-1-c.
  always_comb begin
    s2_pix_d = '0;
    r_int    = int'(s1_r_q);
    if (s1_err_q) begin
      s2_pix_d = '0;
    end else begin
      case (kind_e'(s1_kind_q))
        KIND_SHIP: begin
          if (r_int < HEIGHT / 2 || r_int == HEIGHT - 1) begin
            s2_pix_d = '1;
          end else begin
            s2_pix_d = '0;
          end
        end
        KIND_HIT: begin
          for (int c = 0; c < WIDTH; c++) begin
            if (!s1_phase_q && r_int < WIDTH &&
                (c == r_int || c == WIDTH - 1 - r_int)) begin
              s2_pix_d[WIDTH-1-c] = 1'b1;
            end else begin
              s2_pix_d[WIDTH-1-c] = 1'b0;
            end
          end
        end
        KIND_MISS: begin
          for (int c = 0; c < WIDTH; c++) begin
            if (r_int >= MISS_R_LO && r_int <= MISS_R_HI &&
                c >= MISS_C_LO && c <= MISS_C_HI) begin
              s2_pix_d[WIDTH-1-c] = 1'b1;
            end else begin
              s2_pix_d[WIDTH-1-c] = 1'b0;
            end
          end
        end
        KIND_WATER: s2_pix_d = '0;
        default:    s2_pix_d = '0;
      endcase
    end
  end

  // Stage 2 / output holding: data registers only move when a line is present.
  always_comb begin
    s2_row_d      = s2_row_q;
    s2_err_d      = s2_err_q;
    line_pixels_d = line_pixels_q;
    line_row_d    = line_row_q;
    row_err_d     = row_err_q;
    if (s1_valid_q) begin
      s2_row_d = s1_row_q;
      s2_err_d = s1_err_q;
    end else begin
      s2_row_d = s2_row_q;
    end
    if (s2_valid_q) begin
      line_pixels_d = s2_pix_q;
      line_row_d    = s2_row_q;
      row_err_d     = s2_err_q;
    end else begin
      line_pixels_d = line_pixels_q;
    end
  end

  // Blink state and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      req_ready_q   <= 1'b1;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Pipeline registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_kind_q     <= 2'd0;
      s1_err_q      <= 1'b0;
      s1_r_q        <= '0;
      s1_row_q      <= '0;
      s1_phase_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_pix_q      <= '0;
      s2_row_q      <= '0;
      s2_err_q      <= 1'b0;
      line_valid_q  <= 1'b0;
      line_pixels_q <= '0;
      line_row_q    <= '0;
      row_err_q     <= 1'b0;
    end else begin
      s1_valid_q    <= accept_s;
      s1_kind_q     <= s1_kind_d;
      s1_err_q      <= s1_err_d;
      s1_r_q        <= s1_r_d;
      s1_row_q      <= s1_row_d;
      s1_phase_q    <= s1_phase_d;
      s2_valid_q    <= s1_valid_q;
      s2_pix_q      <= s1_valid_q ? s2_pix_d : s2_pix_q;
      s2_row_q      <= s2_row_d;
      s2_err_q      <= s2_err_d;
      line_valid_q  <= s2_valid_q;
      line_pixels_q <= line_pixels_d;
      line_row_q    <= line_row_d;
      row_err_q     <= row_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign line_valid  = line_valid_q;
  assign line_pixels = line_pixels_q;
  assign line_row    = line_row_q;
  assign row_err     = row_err_q;

endmodule

// File: tb/tb_ship_sprite_rom.sv
// Directed bench for ship_sprite_rom with default parameters. Requests carry
// hand-computed expected lines; a monitor matches returned lines in order and
// checks their arrival cycle.

module tb_ship_sprite_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [6:0]  req_row;
  logic        req_mirror;
  logic        frame_tick;
  logic        line_valid;
  logic [47:0] line_pixels;
  logic [6:0]  line_row;
  logic        row_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int line_cnt = 0;

  typedef struct {
    logic [47:0] px;
    logic [6:0]  row;
    logic        er;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [47:0] ONES = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] XPAT = 48'h800000000001;
  localparam logic [47:0] DOT  = 48'h00000FF00000;

  ship_sprite_rom dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_row     (req_row),
    .req_mirror  (req_mirror),
    .frame_tick  (frame_tick),
    .line_valid  (line_valid),
    .line_pixels (line_pixels),
    .line_row    (line_row),
    .row_err     (row_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && line_valid) begin
      exp_t e;
      line_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_line", 64'(line_row), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("pixels_row%0d", e.row), 64'(line_pixels), 64'(e.px));
        check_eq($sformatf("line_row%0d", e.row), 64'(line_row), 64'(e.row));
        check_eq($sformatf("row_err%0d", e.row), 64'(row_err), 64'(e.er));
        check_eq($sformatf("latency_row%0d", e.row), 64'(cyc), 64'(e.due));
      end
    end
  end

  // Drive one request for one cycle (called on a falling edge).
  task automatic req(input logic [1:0] k, input logic [6:0] row, input logic m,
                     input logic [47:0] px, input logic er);
    exp_t e;
    req_valid  = 1'b1;
    req_kind   = k;
    req_row    = row;
    req_mirror = m;
    e.px = px; e.row = row; e.er = er; e.due = cyc + 3;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    int lines_before;
    rst = 1'b1; req_valid = 1'b0; req_kind = 2'd0; req_row = 7'd0;
    req_mirror = 1'b0; frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;  // ignored while in reset
    @(negedge clk);
    frame_tick = 1'b0;
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_line_valid", 64'(line_valid), 64'd0);
    check_eq("rst_pixels", 64'(line_pixels), 64'd0);
    check_eq("rst_line_row", 64'(line_row), 64'd0);
    check_eq("rst_row_err", 64'(row_err), 64'd0);
    rst = 1'b0;
    check_eq("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("ready_after_edge", 64'(req_ready), 64'd1);

    // SHIP back-to-back, no mirror
    req(2'd0, 7'd0,  1'b0, ONES,  1'b0);
    req(2'd0, 7'd23, 1'b0, ONES,  1'b0);
    req(2'd0, 7'd24, 1'b0, 48'd0, 1'b0);
    req(2'd0, 7'd46, 1'b0, 48'd0, 1'b0);
    req(2'd0, 7'd47, 1'b0, ONES,  1'b0);
    // SHIP mirrored: 0->47, 24->23, 47->0, 23->24
    req(2'd0, 7'd0,  1'b1, ONES,  1'b0);
    req(2'd0, 7'd24, 1'b1, ONES,  1'b0);
    req(2'd0, 7'd47, 1'b1, ONES,  1'b0);
    req(2'd0, 7'd23, 1'b1, 48'd0, 1'b0);
    // HIT with phase 0
    req(2'd1, 7'd0,  1'b0, XPAT, 1'b0);
    req(2'd1, 7'd23, 1'b0, 48'h000001800000, 1'b0);
    idle(4);

    // Blink: 16 ticks -> phase 1
    ticks(16);
    req(2'd1, 7'd0, 1'b0, 48'd0, 1'b0);
    idle(1);
    // 15 ticks, then a tick coincident with an accept: request sees old phase
    ticks(15);
    frame_tick = 1'b1;
    req(2'd1, 7'd0, 1'b0, 48'd0, 1'b0);
    frame_tick = 1'b0;
    req(2'd1, 7'd0, 1'b0, XPAT, 1'b0);

    // MISS boundaries and WATER
    req(2'd2, 7'd19, 1'b0, 48'd0, 1'b0);
    req(2'd2, 7'd20, 1'b0, DOT,   1'b0);
    req(2'd2, 7'd27, 1'b0, DOT,   1'b0);
    req(2'd2, 7'd28, 1'b0, 48'd0, 1'b0);
    req(2'd2, 7'd20, 1'b1, DOT,   1'b0);  // r = 27
    req(2'd3, 7'd10, 1'b0, 48'd0, 1'b0);
    // Out-of-range rows
    req(2'd0, 7'd48,  1'b1, 48'd0, 1'b1);
    req(2'd1, 7'd127, 1'b1, 48'd0, 1'b1);
    idle(5);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two requests in flight: both are dropped
    req_valid = 1'b1; req_kind = 2'd0; req_row = 7'd0; req_mirror = 1'b0;
    @(negedge clk);
    req_row = 7'd1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("ready_low_after_midrst", 64'(req_ready), 64'd0);
    check_eq("valid_low_after_midrst", 64'(line_valid), 64'd0);
    @(negedge clk);
    check_eq("ready_high_after_midrst", 64'(req_ready), 64'd1);
    lines_before = line_cnt;
    req(2'd2, 7'd24, 1'b0, DOT, 1'b0);
    idle(6);
    check_eq("one_line_after_rst", 64'(line_cnt - lines_before), 64'd1);
    check_eq("queue_final", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
